// File: rtl/package_settings.sv
// rtl/package_settings.sv - project-wide datapath widths
package package_settings;

  localparam int SIZE_FILTER_DATA = 16;

endpackage

// File: rtl/v1_parameters.sv
// rtl/v1_parameters.sv - Variant 1 peak detector defaults and FSM state type
package v1_parameters;

  import package_settings::*;

  localparam int SIZE_FILTER_DATA_1 = SIZE_FILTER_DATA;
  localparam int THRESHOLD_1        = 200;
  localparam int MIN_WIDTH_1        = 3;
  localparam int HOLDOFF_1          = 8;
  localparam int TS_WIDTH_1         = 32;
  localparam int W_WIDTH_1          = 8;

  typedef enum logic [1:0] {IDLE, ABOVE, HOLDOFF} v1_pd_state_t;

endpackage

// File: rtl/v1_peak_result_buffer.sv
// rtl/v1_peak_result_buffer.sv - single-entry valid/ready result register
// A new result arriving while the held one is still unread is dropped and counted.
module v1_peak_result_buffer #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32,
  parameter int W_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              emit,
  input  logic [DATA_W-1:0] emit_amplitude,
  input  logic [TS_W-1:0]   emit_time,
  input  logic [W_W-1:0]    emit_width,
  input  logic              peak_ready,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_amplitude,
  output logic [TS_W-1:0]   peak_time,
  output logic [W_W-1:0]    peak_width,
  output logic [15:0]       lost_count
);

  logic transfer;
  logic accept;

  assign transfer = peak_valid && peak_ready;
  assign accept   = emit && (!peak_valid || transfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      lost_count     <= '0;
    end else begin
      if (accept) begin
        peak_valid     <= 1'b1;
        peak_amplitude <= emit_amplitude;
        peak_time      <= emit_time;
        peak_width     <= emit_width;
      end else if (transfer) begin
        peak_valid <= 1'b0;
      end
      if (emit && !accept && lost_count != 16'hFFFF) begin
        lost_count <= lost_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/v1_peak_detector.sv
// rtl/v1_peak_detector.sv - threshold pulse finder reporting peak, time and width
// Glitches shorter than MIN_WIDTH are discarded; crossings during holdoff are treated as pile-up.
module v1_peak_detector #(
  parameter int SIZE_FILTER_DATA = v1_parameters::SIZE_FILTER_DATA_1,
  parameter int THRESHOLD        = v1_parameters::THRESHOLD_1,
  parameter int MIN_WIDTH        = v1_parameters::MIN_WIDTH_1,
  parameter int HOLDOFF          = v1_parameters::HOLDOFF_1,
  parameter int TS_WIDTH         = v1_parameters::TS_WIDTH_1,
  parameter int W_WIDTH          = v1_parameters::W_WIDTH_1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic                        peak_ready,
  output logic                        peak_valid,
  output logic [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]         peak_time,
  output logic [W_WIDTH-1:0]          peak_width,
  output logic [15:0]                 lost_count
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic signed [SIZE_FILTER_DATA-1:0] THR = SIZE_FILTER_DATA'(THRESHOLD);
  localparam logic [W_WIDTH-1:0] MIN_W = W_WIDTH'(MIN_WIDTH);
  localparam logic [W_WIDTH-1:0] W_MAX = '1;

  v1_parameters::v1_pd_state_t state, state_next;

  logic signed [SIZE_FILTER_DATA-1:0] s_reg;
  logic                               s_valid;
  logic [TS_WIDTH-1:0]                s_ts;
  logic [TS_WIDTH-1:0]                ts_next;

  logic signed [SIZE_FILTER_DATA-1:0] max_val, max_val_next;
  logic [TS_WIDTH-1:0]                max_ts, max_ts_next;
  logic [W_WIDTH-1:0]                 width, width_next;
  logic [HC_W-1:0]                    hcnt, hcnt_next;
  logic                               qualify;
  logic                               emit;

  // s_valid keeps the reset value of s_reg from being judged as a real sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg   <= '0;
      s_valid <= 1'b0;
      s_ts    <= '0;
      ts_next <= '0;
    end else begin
      s_reg   <= filter_data;
      s_valid <= 1'b1;
      s_ts    <= ts_next;
      ts_next <= ts_next + TS_WIDTH'(1);
    end
  end

  assign qualify = s_valid && (s_reg > THR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= v1_parameters::IDLE;
      max_val <= '0;
      max_ts  <= '0;
      width   <= '0;
      hcnt    <= '0;
    end else begin
      state   <= state_next;
      max_val <= max_val_next;
      max_ts  <= max_ts_next;
      width   <= width_next;
      hcnt    <= hcnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    max_val_next = max_val;
    max_ts_next  = max_ts;
    width_next   = width;
    hcnt_next    = hcnt;
    emit         = 1'b0;
    case (state)
      v1_parameters::IDLE: begin
        if (qualify) begin
          state_next   = v1_parameters::ABOVE;
          max_val_next = s_reg;
          max_ts_next  = s_ts;
          width_next   = W_WIDTH'(1);
        end
      end
      v1_parameters::ABOVE: begin
        if (qualify) begin
          if (width != W_MAX) width_next = width + W_WIDTH'(1);
          // strict compare keeps the timestamp of the first of equal peaks
          if (s_reg > max_val) begin
            max_val_next = s_reg;
            max_ts_next  = s_ts;
          end
        end else if (width >= MIN_W) begin
          emit       = 1'b1;
          hcnt_next  = HOLD_INIT;
          state_next = (HOLDOFF == 0) ? v1_parameters::IDLE : v1_parameters::HOLDOFF;
        end else begin
          state_next = v1_parameters::IDLE;
        end
      end
      v1_parameters::HOLDOFF: begin
        if (qualify) begin
          hcnt_next = HOLD_INIT;
        end else if (hcnt == '0) begin
          state_next = v1_parameters::IDLE;
        end else begin
          hcnt_next = hcnt - HC_W'(1);
        end
      end
      default: state_next = v1_parameters::IDLE;
    endcase
  end

  v1_peak_result_buffer #(
    .DATA_W (SIZE_FILTER_DATA),
    .TS_W   (TS_WIDTH),
    .W_W    (W_WIDTH)
  ) u_result_buffer (
    .clk            (clk),
    .reset          (reset),
    .emit           (emit),
    .emit_amplitude (max_val),
    .emit_time      (max_ts),
    .emit_width     (width),
    .peak_ready     (peak_ready),
    .peak_valid     (peak_valid),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_width     (peak_width),
    .lost_count     (lost_count)
  );

endmodule

// File: tb/tb_v1_peak_detector.sv
// tb/tb_v1_peak_detector.sv - scoreboard bench for v1_peak_detector
module tb_v1_peak_detector;

  localparam int THR       = 200;
  localparam int MIN_WIDTH = 3;
  localparam int HOLDOFF   = 8;

  typedef struct {
    int          amp;
    logic [31:0] ts;
    int          width;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] filter_data = '0;
  logic        peak_ready = 1'b0;
  logic        peak_valid;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic [7:0]  peak_width;
  logic [15:0] lost_count;

  int errors = 0;
  int checks = 0;

  res_t        expq[$];
  int          run_val[$];
  logic [31:0] run_start;
  logic [31:0] midx;
  int          gap;
  bit          hold;
  bit          pend;
  res_t        pend_res;
  bit          mvalid;
  int          mlost;

  int          n_xfer = 0;
  int          last_amp;
  logic [31:0] last_ts;
  int          last_w;

  v1_peak_detector dut (
    .clk            (clk),
    .reset          (reset),
    .filter_data    (filter_data),
    .peak_ready     (peak_ready),
    .peak_valid     (peak_valid),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_width     (peak_width),
    .lost_count     (lost_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    run_val.delete();
    midx   = 0;
    gap    = 0;
    hold   = 0;
    pend   = 0;
    mvalid = 0;
    mlost  = 0;
  endtask

  // Pulse-level model: a pulse is a run of samples above threshold; it is reported
  // when the run ends, then HOLDOFF quiet samples must pass before a new run counts.
  task automatic model_sample(input int v);
    bit q;
    q = v > THR;
    pend = 0;
    if (hold) begin
      if (q) gap = 0;
      else begin
        gap++;
        if (gap >= HOLDOFF) hold = 0;
      end
    end else if (run_val.size() > 0) begin
      if (q) run_val.push_back(v);
      else begin
        if (run_val.size() >= MIN_WIDTH) begin
          int best;
          best = 0;
          for (int i = 1; i < run_val.size(); i++)
            if (run_val[i] > run_val[best]) best = i;
          pend           = 1;
          pend_res.amp   = run_val[best];
          pend_res.ts    = run_start + 32'(best);
          pend_res.width = (run_val.size() > 255) ? 255 : run_val.size();
          if (HOLDOFF > 0) begin
            hold = 1;
            gap  = 0;
          end
        end
        run_val.delete();
      end
    end else if (q) begin
      run_val.push_back(v);
      run_start = midx;
    end
    midx++;
  endtask

  task automatic model_edge(input bit r);
    bit xfer;
    xfer = mvalid && r;
    if (pend && (!mvalid || xfer)) begin
      mvalid = 1;
      expq.push_back(pend_res);
    end else if (pend) begin
      if (mlost < 65535) mlost++;
    end else if (xfer) begin
      mvalid = 0;
    end
  endtask

  task automatic step(input int v, input bit r);
    filter_data = 16'(v);
    peak_ready  = r;
    @(posedge clk);
    #1;
    model_edge(r);
    model_sample(v);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    filter_data = '0;
    peak_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic play(input int seq[$], input bit r);
    foreach (seq[i]) step(seq[i], r);
  endtask

  // Monitor: compares every presented result with the scoreboard head, pops on transfer.
  always @(negedge clk) begin
    if (!reset) begin
      check("peak_valid", peak_valid, mvalid);
      check("lost_count", lost_count, mlost);
      if (peak_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got amp %0d expected none", $signed(peak_amplitude));
        end else begin
          check("peak_amplitude", $signed(peak_amplitude), expq[0].amp);
          check("peak_time", peak_time, expq[0].ts);
          check("peak_width", peak_width, expq[0].width);
          if (peak_ready) begin
            last_amp = int'($signed(peak_amplitude));
            last_ts  = peak_time;
            last_w   = int'(peak_width);
            n_xfer++;
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int base;
    int seq[$];

    do_reset();
    check("reset_valid", peak_valid, 0);
    check("reset_lost", lost_count, 0);
    check("reset_amp", peak_amplitude, 0);

    // basic pulse, latency
    base = n_xfer;
    play('{0, 100, 300, 500, 700, 500, 300, 100}, 1'b1);
    check("basic_not_yet_valid", peak_valid, 0);
    step(0, 1'b1);
    check("basic_valid_latency", peak_valid, 1);
    repeat (12) step(0, 1'b1);
    check("basic_count", n_xfer - base, 1);
    check("basic_amp", last_amp, 700);
    check("basic_time", last_ts, 4);
    check("basic_width", last_w, 5);

    // glitch
    base = n_xfer;
    play('{0, 250, 250, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("glitch_count", n_xfer - base, 0);
    check("glitch_lost", lost_count, 0);

    // plateau, first maximum kept
    do_reset();
    base = n_xfer;
    play('{0, 300, 600, 600, 600, 300, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("plateau_count", n_xfer - base, 1);
    check("plateau_amp", last_amp, 600);
    check("plateau_time", last_ts, 2);
    check("plateau_width", last_w, 5);

    // backpressure
    do_reset();
    base = n_xfer;
    play('{0, 300, 500, 300, 0}, 1'b0);
    repeat (15) step(0, 1'b0);
    play('{400, 400, 400, 0}, 1'b0);
    repeat (12) step(0, 1'b0);
    check("bp_lost", lost_count, 1);
    check("bp_held_amp", $signed(peak_amplitude), 500);
    check("bp_held_valid", peak_valid, 1);
    step(0, 1'b1);
    step(0, 1'b0);
    check("bp_after_xfer_valid", peak_valid, 0);
    check("bp_one_xfer", n_xfer - base, 1);

    // pile-up and holdoff boundary
    do_reset();
    base = n_xfer;
    play('{0, 300, 500, 300, 0, 0, 0, 0, 0, 400, 400, 400, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("pileup_count", n_xfer - base, 1);
    check("pileup_amp", last_amp, 500);
    base = n_xfer;
    play('{300, 300, 300, 0, 0, 0, 0, 0, 0, 0, 0, 300, 300, 300, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("holdoff_short_gap", n_xfer - base, 1);
    base = n_xfer;
    play('{300, 300, 300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 350, 360, 370, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("holdoff_rearm", n_xfer - base, 2);
    check("holdoff_rearm_amp", last_amp, 370);

    // most negative input never triggers
    base = n_xfer;
    repeat (50) step(-32768, 1'b1);
    check("negative_count", n_xfer - base, 0);

    // reset mid-pulse
    play('{0, 300, 500}, 1'b1);
    do_reset();
    check("midreset_valid", peak_valid, 0);
    check("midreset_lost", lost_count, 0);
    base = n_xfer;
    play('{0, 0, 300, 300, 300, 0}, 1'b1);
    repeat (12) step(0, 1'b1);
    check("midreset_count", n_xfer - base, 1);
    check("midreset_time", last_ts, 2);

    // randomized segments with random backpressure
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      int kind;
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        int v;
        bit r;
        r = ($urandom_range(0, 3) != 0);
        case (kind)
          0: v = int'($urandom_range(0, 700)) - 500;
          1: v = 199 + int'($urandom_range(0, 3));
          default: v = 201 + int'($urandom_range(0, 2000));
        endcase
        step(v, r);
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 12)) step(0, ($urandom_range(0, 3) != 0));
    end
    repeat (20) step(0, 1'b1);
    check("drain_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
